uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- Serial UART receiver (8 data bits, optional parity, 1 stop bit) that sits directly upstream of the 8-entry byte receive FIFO.
- Oversamples the asynchronous rx line, validates each frame and pushes each good byte into the FIFO with a one-cycle write pulse.
- Reports framing, parity and overrun errors to the I/O controller as one-cycle pulses.

Parameters:
- SYS_CLK_FREQ, 100000000, clk frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- OVERSAMPLE, 16, ticks per bit; must be even and at least 4.
- PARITY_EN, 0, 1 means a parity bit follows the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- fifo_full  in  1  receive FIFO full flag.
- fifo_write  out  1  one-cycle push strobe to the FIFO.
- fifo_writedata  out  8  received byte; valid whenever fifo_write=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun_err  out  1  one-cycle pulse: good byte dropped because fifo_full=1.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: clk and rst as decided above (rst synchronous, active-high).
  - All outputs 0 and state IDLE.
  - Both synchronizer flops 1; shift register, tick counter and sample counter 0.
  - Reset mid-frame abandons the frame with no write and no error pulse.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Tick generator:
  - DIV = SYS_CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, minimum 1.
  - Counter runs 0..DIV-1; tick is asserted in the cycle the counter equals DIV-1.
  - Counter free-runs and is not reset on frame start.
- States:
  - IDLE: when rx_s=0, clear the sample counter and go to START.
  - START: count ticks. After OVERSAMPLE/2 ticks (mid start bit), sample rx_s.
    - rx_s=0: clear the counters and go to DATA.
    - rx_s=1: false start; go to IDLE with no pulse.
  - DATA: every OVERSAMPLE ticks, sample rx_s and shift it in LSB first. After the 8th bit, go to PARITY if PARITY_EN, otherwise go to STOP.
  - PARITY: after OVERSAMPLE ticks, sample rx_s.
    - Expected value is the XOR of the data bits, inverted when PARITY_ODD.
    - Latch a mismatch flag, then go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s and take exactly one action:
    - rx_s=0: frame_err=1 for one cycle and go to BREAK.
    - rx_s=1 with the mismatch flag set: parity_err=1 and go to IDLE.
    - rx_s=1 with fifo_full=1: overrun_err=1 and go to IDLE.
    - Otherwise: fifo_write=1 for one cycle with fifo_writedata equal to the shifted byte, then go to IDLE.
  - BREAK: wait for rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Return to IDLE happens at mid stop bit, so a back-to-back start bit is caught without a gap.
- Pulse exclusivity:
  - At most one of fifo_write, frame_err, parity_err or overrun_err per frame.
  - frame_err takes priority over parity_err, which takes priority over overrun_err.
- fifo_writedata holds its value until the next successful write.
- fifo_full is sampled only in the STOP decision cycle.
- Latency: fifo_write is asserted within 3 cycles after the STOP mid-bit tick.

Test Plan (SYS_CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16, so DIV=1 and one bit = 16 clk):
- Send frame 0x55 with fifo_full=0 -> exactly one fifo_write, fifo_writedata=0x55, no error pulses, busy returns to 0 after the stop mid-bit.
- Pull rx low for 4 cycles, then idle -> no write and no errors; busy returns to 0 after 8 ticks in START.
- Send 0xA3 with stop bit low, hold rx low for 48 cycles, release, then send 0x3C -> one frame_err, no write for 0xA3, then fifo_write with 0x3C.
- Hold fifo_full=1 and send 0x7E -> one overrun_err, no fifo_write. Drop fifo_full and send 0x81 -> fifo_write with 0x81.
- PARITY_EN=1, PARITY_ODD=0: send 0x01 with parity bit 1 -> write 0x01. Send 0x01 with parity bit 0 -> one parity_err, no write.
- Send 0x00 then 0xFF back-to-back, then assert rst mid-way through a third frame -> writes 0x00 then 0xFF in order; no write or error after rst, and all outputs are 0.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling 8-bit UART receiver that validates frames and pushes good bytes into the receive FIFO
module uart_rx_frontend #(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_EN = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       fifo_write,
  output logic [7:0] fifo_writedata,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun_err,
  output logic       busy
);
  localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_M1 = SW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state;
  logic rx_m, rx_s, tick, mid, full, par_bad;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] s_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  assign tick = div_cnt == DW'(DIV - 1);
  assign mid = tick && s_cnt == HALF_M1;
  assign full = tick && s_cnt == FULL_M1;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      div_cnt <= '0;
      s_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_bad <= 1'b0;
      fifo_write <= 1'b0;
      fifo_writedata <= '0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      fifo_write <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun_err <= 1'b0;
      if (tick && state != IDLE && state != BRK)
        s_cnt <= s_cnt + SW'(1);
      case (state)
        IDLE: if (!rx_s) begin
          s_cnt <= '0;
          par_bad <= 1'b0;
          state <= START;
        end
        START: if (mid) begin
          s_cnt <= '0;
          bit_cnt <= '0;
          state <= rx_s ? IDLE : DATA;
        end
        DATA: if (full) begin
          s_cnt <= '0;
          shreg <= {rx_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= PARITY_EN ? PARITY : STOP;
        end
        PARITY: if (full) begin
          s_cnt <= '0;
          par_bad <= (^shreg ^ PARITY_ODD) != rx_s;
          state <= STOP;
        end
        STOP: if (full) begin
          s_cnt <= '0;
          // leave at mid stop bit so a back-to-back start edge is not missed
          state <= rx_s ? IDLE : BRK;
          if (!rx_s)
            frame_err <= 1'b1;
          else if (par_bad)
            parity_err <= 1'b1;
          else if (fifo_full)
            overrun_err <= 1'b1;
          else begin
            fifo_write <= 1'b1;
            fifo_writedata <= shreg;
          end
        end
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames against a plain and a parity-enabled receiver
module tb_uart_rx_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  logic fifo_full = 1'b0;
  logic fifo_write, frame_err, parity_err, overrun_err, busy;
  logic [7:0] fifo_writedata;
  logic p_write, p_frame, p_parity, p_overrun, p_busy;
  logic [7:0] p_data;
  int checks = 0;
  int errors = 0;
  int wn = 0, fen = 0, pen = 0, ovn = 0;
  int pwn = 0, pfen = 0, ppen = 0, povn = 0;
  int w0, f0, e0, o0, pw0, pf0, pe0, po0;
  logic [7:0] wlog [64];
  logic [7:0] plast = 8'h00;

  always #5 clk = ~clk;

  uart_rx_frontend #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .fifo_full(fifo_full),
    .fifo_write(fifo_write), .fifo_writedata(fifo_writedata), .frame_err(frame_err),
    .parity_err(parity_err), .overrun_err(overrun_err), .busy(busy));

  uart_rx_frontend #(.SYS_CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dutp (
    .clk(clk), .rst(rst), .rx(rx_p), .fifo_full(fifo_full),
    .fifo_write(p_write), .fifo_writedata(p_data), .frame_err(p_frame),
    .parity_err(p_parity), .overrun_err(p_overrun), .busy(p_busy));

  always @(negedge clk) begin
    if (fifo_write) begin
      wlog[wn[5:0]] <= fifo_writedata;
      wn <= wn + 1;
    end
    if (frame_err) fen <= fen + 1;
    if (parity_err) pen <= pen + 1;
    if (overrun_err) ovn <= ovn + 1;
    if (p_write) begin
      plast <= p_data;
      pwn <= pwn + 1;
    end
    if (p_frame) pfen <= pfen + 1;
    if (p_parity) ppen <= ppen + 1;
    if (p_overrun) povn <= povn + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    w0 = wn; f0 = fen; e0 = pen; o0 = ovn;
    pw0 = pwn; pf0 = pfen; pe0 = ppen; po0 = povn;
  endtask

  task automatic deltas(input string tag, input int dw, input int df, input int de, input int dov);
    chk({tag, " writes"}, wn - w0, dw);
    chk({tag, " frame_err"}, fen - f0, df);
    chk({tag, " parity_err"}, pen - e0, de);
    chk({tag, " overrun_err"}, ovn - o0, dov);
  endtask

  task automatic drive(input bit p, input logic v, input int n);
    if (p) rx_p = v;
    else rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit p, input logic [7:0] d, input int par, input logic stop);
    drive(p, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(p, d[i], 16);
    if (par >= 0) drive(p, par[0], 16);
    drive(p, stop, 16);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " fifo_write"}, fifo_write, 0);
    chk({tag, " fifo_writedata"}, fifo_writedata, 0);
    chk({tag, " errs"}, {frame_err, parity_err, overrun_err}, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset p_busy", p_busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    snap();
    send(0, 8'h55, -1, 1'b1);
    deltas("t1 0x55", 1, 0, 0, 0);
    chk("t1 data", wlog[w0[5:0]], 8'h55);
    chk("t1 busy after stop", busy, 0);

    snap();
    drive(0, 1'b0, 4);
    chk("t2 busy in start", busy, 1);
    drive(0, 1'b1, 12);
    chk("t2 busy after false start", busy, 0);
    drive(0, 1'b1, 10);
    deltas("t2 glitch", 0, 0, 0, 0);

    snap();
    send(0, 8'hA3, -1, 1'b0);
    drive(0, 1'b0, 48);
    chk("t3 busy in break", busy, 1);
    drive(0, 1'b1, 20);
    chk("t3 busy after break", busy, 0);
    deltas("t3 break", 0, 1, 0, 0);
    send(0, 8'h3C, -1, 1'b1);
    deltas("t3 total", 1, 1, 0, 0);
    chk("t3 data", wlog[w0[5:0]], 8'h3C);

    snap();
    fifo_full = 1'b1;
    send(0, 8'h7E, -1, 1'b1);
    fifo_full = 1'b0;
    deltas("t4 overrun", 0, 0, 0, 1);
    chk("t4 writedata held", fifo_writedata, 8'h3C);
    send(0, 8'h81, -1, 1'b1);
    deltas("t4 total", 1, 0, 0, 1);
    chk("t4 data", wlog[w0[5:0]], 8'h81);

    snap();
    send(1, 8'h01, 1, 1'b1);
    chk("t5 good writes", pwn - pw0, 1);
    chk("t5 good data", plast, 8'h01);
    chk("t5 good parity_err", ppen - pe0, 0);
    send(1, 8'h01, 0, 1'b1);
    chk("t5 bad writes", pwn - pw0, 1);
    chk("t5 bad parity_err", ppen - pe0, 1);
    chk("t5 frame/overrun", (pfen - pf0) + (povn - po0), 0);
    chk("t5 plain dut quiet", wn - w0, 0);

    snap();
    send(0, 8'h00, -1, 1'b1);
    send(0, 8'hFF, -1, 1'b1);
    drive(0, 1'b1, 4);
    deltas("t6 b2b", 2, 0, 0, 0);
    chk("t6 first", wlog[w0[5:0]], 8'h00);
    chk("t6 second", wlog[6'(w0 + 1)], 8'hFF);
    snap();
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 16);
    drive(0, 1'b0, 8);
    chk("t6 busy mid frame", busy, 1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outputs("t6 rst");
    rst = 1'b0;
    repeat (200) @(negedge clk);
    deltas("t6 after rst", 0, 0, 0, 0);
    chk("t6 busy end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
